// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive bit-unstuffing path.
//   rx_state_e : receive FSM states (IDLE, RUN, DROP)
//   MAX_ONES   : run length of decoded 1s after which the next bit is a stuff bit
//   BYTE_W     : width of an assembled byte
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  localparam logic [2:0] MAX_ONES = 3'd6;
  localparam int         BYTE_W   = 8;

endpackage

// File: rtl/rx_nrzi_dec.sv
// NRZI decoder: holds the previous line level and reports a decoded bit of 1
// when the line did not change, 0 when it toggled.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture level as the reference without consuming a bit (sync K)
//   en         : consume a bit this cycle and advance the reference level
//   level      : raw line level
//   dec_bit    : decoded bit for the current level (valid when en is high)
module rx_nrzi_dec (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic level,
  output logic dec_bit
);

  logic prev_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_level <= 1'b0;
    end else if (load || en) begin
      prev_level <= level;
    end
  end

  assign dec_bit = (level == prev_level);

endmodule

// File: rtl/rx_unstuff.sv
// USB receive bit unstuffer and byte assembler.
// Decodes NRZI line levels, removes the stuff bit that follows six decoded 1s,
// and assembles kept bits LSB-first into bytes.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   bstr        : raw line level
//   bstr_ready  : bstr is valid this cycle; the first valid cycle of a packet
//                 is the final sync K and only sets the NRZI reference
//   done        : one-cycle pulse, end of packet
//   byte_data   : last assembled byte (held until the next byte)
//   byte_valid  : one-cycle pulse, byte_data updated
//   pkt_end     : one-cycle pulse, packet finished
//   resid_bits  : kept bits of an unfinished byte at pkt_end (0 = aligned)
//   stuff_err   : sticky per packet, a stuff bit of 1 was seen
// Build option: define RX_STUFF_ERR_EN to flag a stuff bit of 1 as an error
// and drop the rest of the packet; otherwise such a bit is silently discarded
// and stuff_err stays 0.
//
// Handshake: there is no back-pressure. A line sample is consumed exactly on
// cycles where bstr_ready is 1; on other cycles bstr is ignored and all decode
// state (reference level, counters, shift register) holds.
module rx_unstuff
  import usb_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              bstr,
  input  logic              bstr_ready,
  input  logic              done,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              pkt_end,
  output logic [2:0]        resid_bits,
  output logic              stuff_err
);

  rx_state_e         state, state_nxt;
  logic [2:0]        ones_cnt, ones_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [BYTE_W-1:0] shreg, sh_nxt;
  logic              byte_done;
  logic              nrzi_load, nrzi_en;
  logic              dec_bit;
  logic              err_set, err_clr;
  logic              err_q;

  rx_nrzi_dec u_nrzi (
    .clk     (clk),
    .rst     (rst),
    .load    (nrzi_load),
    .en      (nrzi_en),
    .level   (bstr),
    .dec_bit (dec_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ones_nxt  = ones_cnt;
    bit_nxt   = bit_cnt;
    sh_nxt    = shreg;
    byte_done = 1'b0;
    nrzi_load = 1'b0;
    nrzi_en   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;

    case (state)
      IDLE: begin
        // An end-of-packet with nothing received only produces pkt_end.
        if (!done && bstr_ready) begin
          nrzi_load = 1'b1;
          err_clr   = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (bstr_ready) begin
          nrzi_en = 1'b1;
          if (ones_cnt == MAX_ONES) begin
            // Stuff bit position: never shifted in.
            ones_nxt = 3'd0;
`ifdef RX_STUFF_ERR_EN
            if (dec_bit) begin
              err_set   = 1'b1;
              state_nxt = DROP;
            end
`endif
          end else begin
            ones_nxt = dec_bit ? (ones_cnt + 3'd1) : 3'd0;
            sh_nxt   = {dec_bit, shreg[BYTE_W-1:1]};
            bit_nxt  = bit_cnt + 3'd1;
            byte_done = (bit_cnt == 3'd7);
          end
        end
        if (done) begin
          state_nxt = IDLE;
        end
      end

      DROP: begin
        if (done) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt   <= 3'd0;
      bit_cnt    <= 3'd0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      pkt_end    <= 1'b0;
      resid_bits <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      byte_valid <= byte_done;
      pkt_end    <= done;
      if (byte_done) begin
        byte_data <= sh_nxt;
      end
      if (done) begin
        // Residual count includes a bit kept on the done cycle itself, so a
        // byte completing together with done reports 0.
        resid_bits <= (state == IDLE) ? 3'd0 : bit_nxt;
        ones_cnt   <= 3'd0;
        bit_cnt    <= 3'd0;
        shreg      <= '0;
      end else begin
        ones_cnt <= ones_nxt;
        bit_cnt  <= bit_nxt;
        shreg    <= sh_nxt;
      end
      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign stuff_err = err_q;

endmodule

// File: doc/rx_unstuff.md
RX_UNSTUFF -- requirements
Module: rx_unstuff

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: bstr  input  1  raw line level (dp) from the DP/DM reader.
REQ-004 SHALL have ports: bstr_ready  input  1  bstr valid this cycle; first high cycle is the final sync K.
REQ-005 SHALL have ports: done  input  1  one-cycle pulse, packet EOP complete.
REQ-006 SHALL have ports: byte_data  output  8  assembled byte, LSB first on line.
REQ-007 SHALL have ports: byte_valid  output  1  one-cycle pulse, byte_data valid.
REQ-008 SHALL have ports: pkt_end  output  1  one-cycle pulse, packet finished.
REQ-009 SHALL have ports: resid_bits  output  3  kept bits in the unfinished byte at pkt_end; 0 means byte-aligned.
REQ-010 SHALL have ports: stuff_err  output  1  sticky per packet; stuffing violation seen.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DROP.
REQ-012 IDLE: on bstr_ready=1, SHALL latch bstr as prev_level, emit no data bit, and go to RUN.
REQ-013 RUN: on each bstr_ready=1 cycle, SHALL decode NRZI as bit = (bstr == prev_level) and then update prev_level to bstr.
REQ-014 RUN: on cycles with bstr_ready=0, SHALL hold all counters and prev_level.
REQ-015 SHALL count decoded 1s in ones_cnt (3 bits), clearing ones_cnt on any decoded 0.
REQ-016 After ones_cnt reaches 6, the next decoded bit SHALL be treated as a stuffed bit.
REQ-017 If the stuffed bit is 0, it SHALL be discarded, not shifted in, and ones_cnt SHALL clear.
REQ-018 If the stuffed bit is 1, behaviour SHALL follow REQ-029/REQ-030 and the FSM SHALL go to DROP.
REQ-019 Each kept bit SHALL shift into an 8-bit register at the MSB, shifting right, so the first line bit ends up at byte_data[0].
REQ-020 bit_cnt (3 bits) SHALL increment on each kept bit; on the 8th kept bit (bit_cnt wraps 7 to 0), byte_data SHALL be registered and byte_valid SHALL pulse the following cycle (latency 1).
REQ-021 On done=1 from RUN or DROP, the block SHALL pulse pkt_end the next cycle, output resid_bits = bit_cnt, and return to IDLE.
REQ-022 On done=1 from RUN or DROP, the block SHALL clear ones_cnt, bit_cnt and the shift register.
REQ-023 If a byte completes on the same cycle that done is sampled, byte_valid and pkt_end SHALL pulse together and resid_bits SHALL be 0.
REQ-024 DROP: the block SHALL ignore bstr, produce no byte_valid, and leave only on done.
REQ-025 stuff_err SHALL clear when the block enters RUN from IDLE.
REQ-026 done=1 while in IDLE SHALL produce a pkt_end pulse with resid_bits=0.
REQ-027 bstr_ready=0 immediately after IDLE-to-RUN, without done, SHALL keep the block in RUN.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE; byte_data=0, byte_valid=0, pkt_end=0, resid_bits=0, stuff_err=0; all internal counters and prev_level=0. rst SHALL take priority over all inputs, including mid-packet.

Configuration
REQ-029 With RX_STUFF_ERR_EN defined, a stuffed bit of 1 SHALL set stuff_err and move the FSM to DROP.
REQ-030 Without RX_STUFF_ERR_EN, a stuffed bit of 1 SHALL be discarded, ones_cnt SHALL clear, the FSM SHALL stay in RUN, and stuff_err SHALL be tied 0.

Structure
REQ-031 Package usb_rx_pkg SHALL hold the FSM state enum and constants MAX_ONES=6 and BYTE_W=8.
REQ-032 Sub-module rx_nrzi_dec (prev_level register plus XNOR, load/enable inputs) SHALL be instantiated once; unstuffing, assembly and the FSM SHALL live in rx_unstuff.

Verification
REQ-033 Sync-end K then line levels encoding 0xA5 (8 bits), then done -> one byte_valid with byte_data=0xA5, then pkt_end with resid_bits=0.
REQ-034 Decoded stream 1111110 followed by 0 (stuffed 0 after six 1s) -> stuffed bit dropped, byte assembled from kept bits only, stuff_err=0.
REQ-035 Seven consecutive decoded 1s with RX_STUFF_ERR_EN -> stuff_err=1, no further byte_valid, pkt_end on done; without the macro -> stuff_err=0 and assembly continues.
REQ-036 Twelve kept bits then done -> one byte_valid, then pkt_end with resid_bits=4.
REQ-037 rst asserted for one cycle mid-byte, then a new 0x3C packet -> all outputs 0 after reset, and the next packet decodes 0x3C correctly.
REQ-038 Gaps of bstr_ready=0 inserted between bits of 0xC3 -> result identical to the gap-free case (byte_data=0xC3).
